// File: rtl/servo_sched_pkg.sv
// Shared types and default constants for the servo frame scheduler.
package servo_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FSTART,
    SLOT,
    PULSE,
    GAP,
    FWAIT
  } schedState_t;

  typedef logic [11:0] usWidth_t;

  localparam int MAX_CH         = 8;
  localparam int DEF_N_CH       = 8;
  localparam int DEF_TICK_DIV   = 80;
  localparam int DEF_FRAME_US   = 20000;
  localparam int DEF_MIN_US     = 500;
  localparam int DEF_MAX_US     = 2400;
  localparam int DEF_GAP_US     = 10;

  // Zero means "channel disabled" and must survive the clamp untouched.
  function automatic usWidth_t clampUs(input usWidth_t v, input usWidth_t lo, input usWidth_t hi);
    if (v == '0)
      return '0;
    else if (v < lo)
      return lo;
    else if (v > hi)
      return hi;
    else
      return v;
  endfunction

endpackage

// File: rtl/servo_frame_scheduler_timer.sv
// Microsecond down-timer: expired strobes in the last cycle of loadVal*TICK_DIV cycles after load.
// Load restarts the prescaler; clr/reset stop it; no backpressure.
module us_tick_timer
  import servo_sched_pkg::*;
#(
  parameter int TICK_DIV = DEF_TICK_DIV
) (
  input  logic     inCLK,
  input  logic     reset,
  input  logic     clr,
  input  logic     load,
  input  usWidth_t loadVal,
  output logic     expired
);

  localparam int PW = $clog2(TICK_DIV + 1);

  logic [PW-1:0] preCnt;
  usWidth_t      usCnt;
  logic          running;
  logic          lastTick;

  assign lastTick = (preCnt == PW'(TICK_DIV - 1));
  assign expired  = running && lastTick && (usCnt == 12'd1);

  always_ff @(posedge inCLK) begin
    if (reset || clr) begin
      running <= 1'b0;
      preCnt  <= '0;
      usCnt   <= '0;
    end else if (load) begin
      running <= (loadVal != '0);
      preCnt  <= '0;
      usCnt   <= loadVal;
    end else if (running) begin
      if (lastTick) begin
        preCnt <= '0;
        usCnt  <= usCnt - 12'd1;
        if (usCnt == 12'd1)
          running <= 1'b0;
      end else begin
        preCnt <= preCnt + PW'(1);
      end
    end
  end

endmodule

// File: rtl/servo_frame_scheduler.sv
// Time-multiplexed servo pulse scheduler: one shared timer, one pulse per enabled channel per frame.
// First rising edge 2 cycles after frame_start; writes are accepted every cycle, no backpressure.
module servo_frame_scheduler
  import servo_sched_pkg::*;
#(
  parameter int N_CH     = DEF_N_CH,
  parameter int TICK_DIV = DEF_TICK_DIV,
  parameter int FRAME_US = DEF_FRAME_US,
  parameter int MIN_US   = DEF_MIN_US,
  parameter int MAX_US   = DEF_MAX_US,
  parameter int GAP_US   = DEF_GAP_US
) (
  input  logic            inCLK,
  input  logic            reset,
  input  logic            enable,
  input  logic            wr_en,
  input  logic [2:0]      wr_ch,
  input  logic [11:0]     wr_us,
  output logic [N_CH-1:0] servo_out,
  output logic            frame_start,
  output logic [2:0]      active_ch,
  output logic            busy,
  output logic            overrun
);

  localparam int FRAME_CYC = FRAME_US * TICK_DIV;
  localparam int FCW       = $clog2(FRAME_CYC);
  localparam logic [FCW-1:0] FRAME_TC = FCW'(FRAME_CYC - 1);

  schedState_t     state;
  logic [2:0]      ch;
  logic [FCW-1:0]  frameCnt;
  usWidth_t        pend [MAX_CH];
  usWidth_t        act  [MAX_CH];
  logic [MAX_CH-1:0] servoReg;

  logic     wrOk;
  usWidth_t wrVal;
  logic     lastCh;
  logic     frameDone;
  logic     slotLoad;
  logic     tmrLoad;
  usWidth_t tmrVal;
  logic     tmrExpired;

  assign wrOk      = wr_en && (32'(wr_ch) < 32'(N_CH));
  assign wrVal     = clampUs(wr_us, usWidth_t'(MIN_US), usWidth_t'(MAX_US));
  assign lastCh    = (ch == 3'(N_CH - 1));
  assign frameDone = (frameCnt == FRAME_TC);
  assign slotLoad  = (state == SLOT) && (act[ch] != '0);
  assign tmrLoad   = enable && (slotLoad || ((state == PULSE) && tmrExpired));
  assign tmrVal    = (state == SLOT) ? act[ch] : usWidth_t'(GAP_US);
  assign servo_out = servoReg[N_CH-1:0];

  us_tick_timer #(
    .TICK_DIV (TICK_DIV)
  ) uTimer (
    .inCLK   (inCLK),
    .reset   (reset),
    .clr     (!enable),
    .load    (tmrLoad),
    .loadVal (tmrVal),
    .expired (tmrExpired)
  );

  always_ff @(posedge inCLK) begin
    if (reset) begin
      state       <= IDLE;
      ch          <= '0;
      frameCnt    <= '0;
      servoReg    <= '0;
      frame_start <= 1'b0;
      active_ch   <= '0;
      busy        <= 1'b0;
      overrun     <= 1'b0;
      for (int i = 0; i < MAX_CH; i++) begin
        pend[i] <= '0;
        act[i]  <= '0;
      end
    end else begin
      if (wrOk)
        pend[wr_ch] <= wrVal;
      frame_start <= 1'b0;

      if (!enable) begin
        state     <= IDLE;
        ch        <= '0;
        frameCnt  <= '0;
        servoReg  <= '0;
        active_ch <= '0;
        busy      <= 1'b0;
      end else begin
        // Saturating frame counter; a late frame finishes and restarts immediately.
        if (!frameDone)
          frameCnt <= frameCnt + FCW'(1);
        if (frameDone && (state == SLOT || state == PULSE || state == GAP))
          overrun <= 1'b1;

        case (state)
          IDLE: begin
            frameCnt    <= '0;
            state       <= FSTART;
            frame_start <= 1'b1;
          end
          FSTART: begin
            for (int i = 0; i < MAX_CH; i++)
              act[i] <= pend[i];
            if (wrOk)
              act[wr_ch] <= wrVal;
            frameCnt <= '0;
            ch       <= '0;
            state    <= SLOT;
          end
          SLOT: begin
            if (act[ch] != '0) begin
              servoReg  <= MAX_CH'(1) << ch;
              active_ch <= ch;
              busy      <= 1'b1;
              state     <= PULSE;
            end else if (lastCh) begin
              state       <= frameDone ? FSTART : FWAIT;
              frame_start <= frameDone;
            end else begin
              ch <= ch + 3'd1;
            end
          end
          PULSE: begin
            if (tmrExpired) begin
              servoReg <= '0;
              state    <= GAP;
            end
          end
          GAP: begin
            if (tmrExpired) begin
              busy <= 1'b0;
              if (lastCh) begin
                state       <= frameDone ? FSTART : FWAIT;
                frame_start <= frameDone;
              end else begin
                ch    <= ch + 3'd1;
                state <= SLOT;
              end
            end
          end
          FWAIT: begin
            if (frameDone) begin
              state       <= FSTART;
              frame_start <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_servo_frame_scheduler.sv
// Directed bench: instance 0 uses a 100 us frame, instance 1 a 60 us frame that cannot fit four 20 us slots.
module tb_servo_frame_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       enable [2];
  logic       wrEn   [2];
  logic [2:0] wrCh   [2];
  logic [11:0] wrUs  [2];
  logic [3:0] servo  [2];
  logic       frameStart [2];
  logic [2:0] activeCh [2];
  logic       busy   [2];
  logic       overrun [2];

  servo_frame_scheduler #(
    .N_CH(4), .TICK_DIV(2), .FRAME_US(100), .MIN_US(5), .MAX_US(20), .GAP_US(2)
  ) dut (
    .inCLK(clk), .reset(reset), .enable(enable[0]), .wr_en(wrEn[0]), .wr_ch(wrCh[0]),
    .wr_us(wrUs[0]), .servo_out(servo[0]), .frame_start(frameStart[0]),
    .active_ch(activeCh[0]), .busy(busy[0]), .overrun(overrun[0])
  );

  servo_frame_scheduler #(
    .N_CH(4), .TICK_DIV(2), .FRAME_US(60), .MIN_US(5), .MAX_US(20), .GAP_US(2)
  ) dutOv (
    .inCLK(clk), .reset(reset), .enable(enable[1]), .wr_en(wrEn[1]), .wr_ch(wrCh[1]),
    .wr_us(wrUs[1]), .servo_out(servo[1]), .frame_start(frameStart[1]),
    .active_ch(activeCh[1]), .busy(busy[1]), .overrun(overrun[1])
  );

  int nVec = 0;
  int nBad = 0;
  int cyc  = 0;

  int riseT    [2][4] = '{default: 0};
  int fallT    [2][4] = '{default: 0};
  int width    [2][4] = '{default: 0};
  int pulseCnt [2][4] = '{default: 0};
  logic [2:0] actAtRise  [2][4] = '{default: '0};
  logic       busyAtRise [2][4] = '{default: 1'b0};
  int lastFs  [2] = '{default: 0};
  int prevFs  [2] = '{default: 0};
  int fsCnt   [2] = '{default: 0};
  int gapToFs [2] = '{default: 0};
  logic [2:0] ovCh   [2] = '{default: '0};
  logic       prevOv [2] = '{default: 1'b0};
  logic [3:0] prevServo [2] = '{default: '0};
  logic multiHot = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Edge recorder, sampled on the falling clock edge.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 4; i++) begin
        if (servo[d][i] && !prevServo[d][i]) begin
          riseT[d][i]      = cyc;
          actAtRise[d][i]  = activeCh[d];
          busyAtRise[d][i] = busy[d];
        end
        if (!servo[d][i] && prevServo[d][i]) begin
          fallT[d][i]    = cyc;
          width[d][i]    = cyc - riseT[d][i];
          pulseCnt[d][i] = pulseCnt[d][i] + 1;
        end
      end
      if (frameStart[d]) begin
        prevFs[d]  = lastFs[d];
        lastFs[d]  = cyc;
        fsCnt[d]   = fsCnt[d] + 1;
        gapToFs[d] = cyc - fallT[d][3];
      end
      if (overrun[d] && !prevOv[d])
        ovCh[d] = activeCh[d];
      prevOv[d]    = overrun[d];
      prevServo[d] = servo[d];
      if ($countones(servo[d]) > 1)
        multiHot = 1'b1;
    end
  end

  task automatic checkVal(input string tag, input int obs, input int exp);
    nVec++;
    if (obs !== exp) begin
      nBad++;
      $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wr(input int d, input int c, input int us);
    wrEn[d] = 1'b1;
    wrCh[d] = 3'(c);
    wrUs[d] = 12'(us);
    step();
    wrEn[d] = 1'b0;
  endtask

  task automatic waitFs(input int d, input int n, input string tag);
    int k = 0;
    while (fsCnt[d] < n && k < 2000) begin
      step();
      k++;
    end
    checkVal(tag, fsCnt[d], n);
  endtask

  task automatic waitLevel(input int d, input int c, input logic v, input string tag);
    int k = 0;
    while (servo[d][c] !== v && k < 2000) begin
      step();
      k++;
    end
    checkVal(tag, int'(servo[d][c]), int'(v));
  endtask

  initial begin
    int f;
    int c3;
    int sumBefore;
    int sumAfter;

    reset = 1'b1;
    for (int d = 0; d < 2; d++) begin
      enable[d] = 1'b0;
      wrEn[d]   = 1'b0;
      wrCh[d]   = '0;
      wrUs[d]   = '0;
    end
    repeat (3) step();
    checkVal("rst_servo", int'(servo[0]), 0);
    checkVal("rst_fs", int'(frameStart[0]), 0);
    checkVal("rst_active", int'(activeCh[0]), 0);
    checkVal("rst_busy", int'(busy[0]), 0);
    checkVal("rst_overrun", int'(overrun[0]), 0);
    reset = 1'b0;
    step();

    // Overrun: 4 x (1 slot + 40 high + 4 gap) = 180 cycles against a 120-cycle frame.
    for (int c = 0; c < 4; c++) wr(1, c, 20);
    enable[1] = 1'b1;
    waitFs(1, 3, "ov_frames");
    for (int c = 0; c < 4; c++) checkVal($sformatf("ov_width%0d", c), width[1][c], 40);
    checkVal("ov_period", lastFs[1] - prevFs[1], 181);
    checkVal("ov_gap_to_fs", gapToFs[1], 4);
    checkVal("ov_flag", int'(overrun[1]), 1);
    checkVal("ov_channel", int'(ovCh[1]), 2);
    enable[1] = 1'b0;

    // Basic frame: ch0=10us, ch2=7us.
    wr(0, 0, 10);
    wr(0, 2, 7);
    enable[0] = 1'b1;
    waitFs(0, 3, "basic_frames");
    checkVal("basic_w0", width[0][0], 20);
    checkVal("basic_w2", width[0][2], 14);
    checkVal("basic_first_rise", riseT[0][0] - prevFs[0], 2);
    // 4 gap cycles + disabled ch1 slot + ch2 slot before ch2 rises.
    checkVal("basic_fall0_rise2", riseT[0][2] - fallT[0][0], 6);
    checkVal("basic_period", lastFs[0] - prevFs[0], 201);
    checkVal("basic_ch1_quiet", pulseCnt[0][1], 0);
    checkVal("basic_ch3_quiet", pulseCnt[0][3], 0);
    checkVal("basic_active2", int'(actAtRise[0][2]), 2);
    checkVal("basic_busy2", int'(busyAtRise[0][2]), 1);
    checkVal("basic_no_overrun", int'(overrun[0]), 0);

    // Clamping and out-of-range writes.
    wr(0, 1, 2);
    f = fsCnt[0];
    waitFs(0, f + 2, "clamp_lo_frames");
    checkVal("clamp_lo_w1", width[0][1], 10);
    wr(0, 1, 4095);
    f = fsCnt[0];
    waitFs(0, f + 2, "clamp_hi_frames");
    checkVal("clamp_hi_w1", width[0][1], 40);
    c3 = pulseCnt[0][3];
    wr(0, 5, 9);
    f = fsCnt[0];
    waitFs(0, f + 2, "ignore_frames");
    checkVal("ignore_w1", width[0][1], 40);
    checkVal("ignore_w0", width[0][0], 20);
    checkVal("ignore_ch3", pulseCnt[0][3], c3);

    // Double buffering: a mid-pulse write waits for the next frame.
    waitLevel(0, 0, 1'b1, "dbuf_rise");
    repeat (5) step();
    wr(0, 0, 15);
    waitLevel(0, 0, 1'b0, "dbuf_fall");
    checkVal("dbuf_current_w0", width[0][0], 20);
    f = fsCnt[0];
    waitFs(0, f + 2, "dbuf_frames");
    checkVal("dbuf_next_w0", width[0][0], 30);
    begin
      int k = 0;
      while (!frameStart[0] && k < 2000) begin
        step();
        k++;
      end
    end
    checkVal("fstart_seen", int'(frameStart[0]), 1);
    wr(0, 0, 8);
    waitLevel(0, 0, 1'b1, "fstart_rise");
    waitLevel(0, 0, 1'b0, "fstart_fall");
    checkVal("fstart_write_w0", width[0][0], 16);

    // Enable drop mid-pulse, then re-enable.
    waitLevel(0, 0, 1'b1, "endrop_rise");
    repeat (4) step();
    enable[0] = 1'b0;
    step();
    checkVal("endrop_servo", int'(servo[0]), 0);
    checkVal("endrop_busy", int'(busy[0]), 0);
    repeat (3) step();
    enable[0] = 1'b1;
    step();
    checkVal("reen_fs", int'(frameStart[0]), 1);
    f = fsCnt[0];
    waitFs(0, f + 1, "reen_frames");
    checkVal("reen_w0", width[0][0], 16);
    checkVal("reen_w2", width[0][2], 14);

    // Reset during the gap after ch2.
    waitLevel(0, 2, 1'b1, "rst_mid_rise");
    waitLevel(0, 2, 1'b0, "rst_mid_fall");
    step();
    reset = 1'b1;
    step();
    checkVal("rst_mid_servo", int'(servo[0]), 0);
    checkVal("rst_mid_busy", int'(busy[0]), 0);
    checkVal("rst_mid_active", int'(activeCh[0]), 0);
    checkVal("rst_mid_fs", int'(frameStart[0]), 0);
    reset = 1'b0;
    sumBefore = pulseCnt[0][0] + pulseCnt[0][1] + pulseCnt[0][2] + pulseCnt[0][3];
    f = fsCnt[0];
    waitFs(0, f + 2, "rst_mid_frames");
    sumAfter = pulseCnt[0][0] + pulseCnt[0][1] + pulseCnt[0][2] + pulseCnt[0][3];
    checkVal("rst_mid_no_pulses", sumAfter, sumBefore);
    checkVal("rst_mid_period", lastFs[0] - prevFs[0], 201);
    checkVal("rst_mid_overrun", int'(overrun[0]), 0);

    checkVal("one_hot", int'(multiHot), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nBad);
    $finish;
  end

endmodule
